// File: rtl/operand_fetch.sv
// Operand fetch: 8x8 register file, source select/negate, one-entry valid/ready output register.
// 1-cycle issue latency, no bubble on consume+accept. Optional write-to-read forwarding: OPERAND_FETCH_BYPASS_EN.
module operand_fetch (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       WRITE,
  input  logic [2:0] WRITEREG,
  input  logic [7:0] IN,
  input  logic       ISSUE_VALID,
  output logic       ISSUE_READY,
  input  logic [2:0] READREG1,
  input  logic [2:0] READREG2,
  input  logic [7:0] IMMEDIATE,
  input  logic       IMM_SEL,
  input  logic       NEG_SEL,
  input  logic [2:0] ALUOP,
  output logic [7:0] DATA1,
  output logic [7:0] DATA2,
  output logic [2:0] SELECT,
  output logic       OP_VALID,
  input  logic       OP_READY
);

  logic [7:0] regs_q [8];
  logic [7:0] regs_d [8];
  logic [7:0] data1_q, data1_d;
  logic [7:0] data2_q, data2_d;
  logic [2:0] select_q, select_d;
  logic       op_valid_q, op_valid_d;

  logic [7:0] s1;
  logic [7:0] s2;
  logic [7:0] operand2;
  logic       accept;

  always_comb begin
    regs_d = regs_q;
    if (WRITE) regs_d[WRITEREG] = IN;
  end

`ifdef OPERAND_FETCH_BYPASS_EN
  // An in-flight writeback wins over the stored value; the immediate is never bypassed.
  always_comb begin
    s1 = (WRITE && (WRITEREG == READREG1)) ? IN : regs_q[READREG1];
    if (IMM_SEL)                                s2 = IMMEDIATE;
    else if (WRITE && (WRITEREG == READREG2))   s2 = IN;
    else                                        s2 = regs_q[READREG2];
  end
`else
  always_comb begin
    s1 = regs_q[READREG1];
    s2 = IMM_SEL ? IMMEDIATE : regs_q[READREG2];
  end
`endif

  assign operand2    = NEG_SEL ? (~s2 + 8'd1) : s2;
  assign ISSUE_READY = !op_valid_q || OP_READY;
  assign accept      = ISSUE_VALID && ISSUE_READY && RESET;

  always_comb begin
    data1_d    = data1_q;
    data2_d    = data2_q;
    select_d   = select_q;
    op_valid_d = op_valid_q;
    if (accept) begin
      data1_d    = s1;
      data2_d    = operand2;
      select_d   = ALUOP;
      op_valid_d = 1'b1;
    end else if (op_valid_q && OP_READY) begin
      op_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= 8'h00;
      data1_q    <= 8'h00;
      data2_q    <= 8'h00;
      select_q   <= 3'd0;
      op_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) regs_q[i] <= regs_d[i];
      data1_q    <= data1_d;
      data2_q    <= data2_d;
      select_q   <= select_d;
      op_valid_q <= op_valid_d;
    end
  end

  assign DATA1    = data1_q;
  assign DATA2    = data2_q;
  assign SELECT   = select_q;
  assign OP_VALID = op_valid_q;

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 The block SHALL have one clock and synchronous, active-low reset: CLK clocks all state, and RESET is sampled only on the rising edge of CLK with reset active when RESET=0.
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 RESET  input  1  synchronous active-low reset.
REQ-004 WRITE  input  1  writeback enable.
REQ-005 WRITEREG  input  3  writeback register address.
REQ-006 IN  input  8  writeback data.
REQ-007 ISSUE_VALID  input  1  decoded instruction presented.
REQ-008 ISSUE_READY  output  1  stage can accept the instruction this cycle.
REQ-009 READREG1  input  3  source-1 register address.
REQ-010 READREG2  input  3  source-2 register address.
REQ-011 IMMEDIATE  input  8  immediate operand.
REQ-012 IMM_SEL  input  1  1 selects IMMEDIATE as source 2.
REQ-013 NEG_SEL  input  1  1 negates source 2 (two's complement).
REQ-014 ALUOP  input  3  ALU select code: 000 forward, 001 add, 010 and, 011 or.
REQ-015 DATA1  output  8  registered ALU operand 1.
REQ-016 DATA2  output  8  registered ALU operand 2.
REQ-017 SELECT  output  3  registered ALU select.
REQ-018 OP_VALID  output  1  DATA1, DATA2 and SELECT hold a valid operation.
REQ-019 OP_READY  input  1  ALU consumes the operation this cycle.

Function
REQ-020 The block SHALL contain 8 registers of 8 bits each, addressed 0-7, with no hardwired register.
REQ-021 A register write SHALL occur on the rising edge when RESET=1 and WRITE=1: REG[WRITEREG] <= IN.
REQ-022 Source values SHALL be read combinationally: s1 = REG[READREG1]; s2 = IMM_SEL ? IMMEDIATE : REG[READREG2].
REQ-023 Operand 2 SHALL be NEG_SEL ? (~s2 + 1) mod 256 : s2, with 8'h00 mapping to 8'h00 and 8'h80 to 8'h80.
REQ-024 ISSUE_READY SHALL equal (!OP_VALID || OP_READY) combinationally.
REQ-025 Accept = ISSUE_VALID && ISSUE_READY && RESET; on accept the edge SHALL load DATA1=s1, DATA2=operand 2, SELECT=ALUOP and set OP_VALID=1, giving 1-cycle latency.
REQ-026 When OP_VALID=1, OP_READY=1 and there is no accept, the edge SHALL clear OP_VALID; DATA1, DATA2 and SELECT hold their values.
REQ-027 When OP_VALID=1 and OP_READY=0, DATA1, DATA2, SELECT and OP_VALID SHALL remain stable regardless of ISSUE_VALID.
REQ-028 A consume and an accept in the same cycle SHALL replace the output with the new operation, with OP_VALID staying 1 (no bubble).
REQ-029 ALUOP values 100-111 SHALL pass through to SELECT unchanged.
REQ-030 A write and an accept in the same cycle SHALL both take effect; the operand value follows REQ-036.

Reset
REQ-031 On an edge with RESET=0, all 8 registers SHALL clear to 8'h00.
REQ-032 On the same edge, DATA1, DATA2 and SELECT SHALL clear to 0 and OP_VALID to 0, so ISSUE_READY=1 after reset.
REQ-033 On an edge with RESET=0, WRITE and ISSUE_VALID SHALL be ignored.
REQ-034 Reset asserted while OP_VALID=1 SHALL drop the pending operation with no consume.

Configuration
REQ-035 Macro OPERAND_FETCH_BYPASS_EN SHALL control write-to-read forwarding.
REQ-036 With the macro defined, when WRITE=1 and a read address equals WRITEREG (READREG2 only when IMM_SEL=0), the source value SHALL be IN; without it, the source SHALL be the pre-edge register contents.

Verification
REQ-037 Reset check: RESET=0 for 1 edge with WRITE=1, WRITEREG=1, IN=8'hAA -> REG[1]=00, OP_VALID=0, ISSUE_READY=1.
REQ-038 Subtract path: write R2=05, R3=03; issue READREG1=2, READREG2=3, NEG_SEL=1, ALUOP=001 -> next edge DATA1=05, DATA2=FD, SELECT=001, OP_VALID=1.
REQ-039 Backpressure: OP_VALID=1, OP_READY=0, new issue -> ISSUE_READY=0 and outputs unchanged for 3 cycles; OP_READY=1 -> new operation loads on the same edge.
REQ-040 Immediate corner: IMM_SEL=1, IMMEDIATE=80, NEG_SEL=1 -> DATA2=80; IMMEDIATE=00, NEG_SEL=1 -> DATA2=00.
REQ-041 Same-cycle hazard: R4=11, WRITE=1, WRITEREG=4, IN=22 with issue READREG1=4 -> DATA1=22 with the macro, DATA1=11 without; R4=22 after the edge in both builds.
REQ-042 Mid-operation reset: OP_VALID=1, OP_READY=0, RESET=0 for one edge -> OP_VALID=0, DATA1=00, all registers 00.
